// File: rtl/rtype_pkg.sv
// rtl/rtype_pkg.sv - state encoding, decode constants and decode helper for rtype_seq
package rtype_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLLV = 6'b000100;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLLV = 3'b111;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    logic       legal;
    logic [2:0] op;
  } dec_t;

  // Only the opcode and funct fields take part in legality; shamt is don't-care.
  function automatic dec_t decode_inst(input logic [31:0] ir);
    dec_t d;
    d.legal = 1'b0;
    d.op    = ALU_AND;
    if (ir[31:26] == OPC_RTYPE) begin
      d.legal = 1'b1;
      case (ir[5:0])
        FN_AND:  d.op = ALU_AND;
        FN_OR:   d.op = ALU_OR;
        FN_XOR:  d.op = ALU_XOR;
        FN_NOR:  d.op = ALU_NOR;
        FN_ADD:  d.op = ALU_ADD;
        FN_SUB:  d.op = ALU_SUB;
        FN_SLTU: d.op = ALU_SLTU;
        FN_SLLV: d.op = ALU_SLLV;
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/regfile_32x32.sv
// rtl/regfile_32x32.sv - 32x32 register file, two operand reads, one debug read, one write port
module regfile_32x32 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  output logic [31:0] o_rdata_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_b,
  input  logic [4:0]  i_raddr_d,
  output logic [31:0] o_rdata_d
);

  logic [31:0] r_mem [32];

  // Synchronous clear of every entry; writes to entry 0 are dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : r_mem[i_raddr_b];
  assign o_rdata_d = (i_raddr_d == 5'd0) ? 32'd0 : r_mem[i_raddr_d];

endmodule

// File: rtl/rtype_seq.sv
// rtl/rtype_seq.sv - four-phase R-type instruction sequencer driving an external ALU
module rtype_seq
  import rtype_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_f,
  input  logic        alu_zf,
  input  logic        alu_of,
  output logic        zf,
  output logic        of,
  output logic        halted,
  output logic        illegal,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic [2:0]  r_alu_op;
  logic        r_pend;
  logic        r_legal;
  logic        r_zf;
  logic        r_of;
  logic        r_halted;
  logic        r_illegal;

  logic        w_inst_req;
  logic        w_fire;
  logic        w_is_halt;
  dec_t        w_dec;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  // Request is combinational so an ack in the first FETCH cycle is possible;
  // r_pend keeps an outstanding request alive if run drops before the ack.
  assign w_inst_req = (r_state == ST_FETCH) && (run || r_pend);
  assign w_fire     = w_inst_req && inst_ack;
  assign w_is_halt  = (r_ir == HALT_WORD);
  assign w_dec      = decode_inst(r_ir);

  regfile_32x32 u_regfile (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (r_ir[25:21]),
    .o_rdata_a (w_rs_data),
    .i_raddr_b (r_ir[20:16]),
    .o_rdata_b (w_rt_data),
    .i_raddr_d (dbg_addr),
    .o_rdata_d (dbg_rdata)
  );

  // Single write port: writeback in WB, debug writes only while idle in FETCH.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = 5'd0;
    w_rf_wdata = 32'd0;
    if ((r_state == ST_WB) && r_legal) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = r_ir[15:11];
      w_rf_wdata = r_result;
    end else if (dbg_we && (r_state == ST_FETCH) && !w_inst_req && !run) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = dbg_addr;
      w_rf_wdata = dbg_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next-state: fixed FETCH-DECODE-EXEC-WB ring, HALT only leaves on reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH:  if (w_fire) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = w_is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC:   w_state_nxt = ST_WB;
      ST_WB:     w_state_nxt = ST_FETCH;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  // Datapath registers; illegal instructions leave ALU drive and flags untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_alu_op  <= ALU_AND;
      r_pend    <= 1'b0;
      r_legal   <= 1'b0;
      r_zf      <= 1'b0;
      r_of      <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_fire) begin
            r_ir   <= inst_data;
            r_pend <= 1'b0;
          end else if (w_inst_req) begin
            r_pend <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_legal  <= 1'b0;
          end else begin
            r_legal <= w_dec.legal;
            if (w_dec.legal) begin
              r_a      <= w_rs_data;
              r_b      <= w_rt_data;
              r_alu_op <= w_dec.op;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (r_legal) begin
            r_result <= alu_f;
            r_zf     <= alu_zf;
            r_of     <= alu_of;
          end
        end
        ST_WB: begin
          r_pc <= r_pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

  assign inst_req  = w_inst_req;
  assign inst_addr = r_pc;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_alu_op;
  assign zf        = r_zf;
  assign of        = r_of;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_rtype_seq.sv
// tb/tb_rtype_seq.sv - self-checking bench for rtype_seq with external ALU and reference model
module tb_rtype_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_data;
  logic [31:0] alu_a, alu_b, alu_f;
  logic [2:0]  alu_op;
  logic        alu_zf, alu_of;
  logic        zf, of, halted, illegal;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;

  always #5 clk = ~clk;

  rtype_seq dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_data(inst_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
    .zf(zf), .of(of), .halted(halted), .illegal(illegal),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  // External ALU keyed by the 3-bit op code.
  always_comb begin
    alu_f  = 32'd0;
    alu_of = 1'b0;
    case (alu_op)
      3'b000: alu_f = alu_a & alu_b;
      3'b001: alu_f = alu_a | alu_b;
      3'b010: alu_f = alu_a ^ alu_b;
      3'b011: alu_f = ~(alu_a | alu_b);
      3'b100: begin
        alu_f  = alu_a + alu_b;
        alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
      end
      3'b101: begin
        alu_f  = alu_a - alu_b;
        alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
      end
      3'b110: alu_f = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_f = alu_b << alu_a[4:0];
    endcase
    alu_zf = (alu_f == 32'd0);
  end

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_pc;
  logic        m_zf, m_of, m_ill, m_halt;
  logic [5:0]  fn_tab [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_pc = 32'd0; m_zf = 1'b0; m_of = 1'b0; m_ill = 1'b0; m_halt = 1'b0;
  endfunction

  // Architectural effect of one instruction word, computed from funct semantics.
  function automatic void model_apply(input logic [31:0] w);
    logic [31:0] a, b, f;
    longint      s;
    bit          ok, v;
    if (w == 32'hFFFF_FFFF) begin
      m_halt = 1'b1;
      return;
    end
    a = m_reg[w[25:21]]; b = m_reg[w[20:16]];
    ok = (w[31:26] == 6'd0); f = 32'd0; v = 1'b0; s = 0;
    if (ok) begin
      case (w[5:0])
        6'h24: f = a & b;
        6'h25: f = a | b;
        6'h26: f = a ^ b;
        6'h27: f = ~(a | b);
        6'h20: begin
          s = longint'($signed(a)) + longint'($signed(b));
          f = s[31:0];
          v = (s != longint'($signed(f)));
        end
        6'h22: begin
          s = longint'($signed(a)) - longint'($signed(b));
          f = s[31:0];
          v = (s != longint'($signed(f)));
        end
        6'h2B: f = (a < b) ? 32'd1 : 32'd0;
        6'h04: f = b << a[4:0];
        default: ok = 1'b0;
      endcase
    end
    if (ok) begin
      m_zf = (f == 32'd0);
      m_of = v;
      if (w[15:11] != 5'd0) m_reg[w[15:11]] = f;
    end else begin
      m_ill = 1'b1;
    end
    m_pc = m_pc + 32'd4;
  endfunction

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_we = 1'b0;
    if (!m_halt && a != 5'd0) m_reg[a] = d;
  endtask

  task automatic chk_reg(input string nm, input logic [4:0] a);
    @(negedge clk);
    dbg_addr = a;
    #1;
    chk($sformatf("%s_r%0d", nm, a), dbg_rdata, m_reg[a]);
  endtask

  task automatic sweep(input string nm);
    for (int i = 0; i < 32; i++) chk_reg(nm, 5'(i));
  endtask

  // Fetch handshake with optional ack delay; returns cycle count and the EXEC-cycle alu_op.
  task automatic run_inst(input logic [31:0] w, input int dly, input bit drop,
                          output int cyc, output logic [2:0] op_seen, output bit to);
    cyc = 0; to = 1'b1; op_seen = 3'd0;
    @(negedge clk);
    run = 1'b1; inst_ack = 1'b0; inst_data = 32'hFC00_0000;
    for (int d = 0; d < dly; d++) begin
      #1;
      chk("req_wait", {31'd0, inst_req}, 32'd1);
      chk("addr_wait", inst_addr, m_pc);
      @(negedge clk);
      cyc++;
      if (drop) run = 1'b0;
    end
    #1;
    chk("req_ack", {31'd0, inst_req}, 32'd1);
    chk("addr_ack", inst_addr, m_pc);
    inst_ack = 1'b1; inst_data = w;
    @(negedge clk);
    cyc++;
    inst_ack = 1'b0; inst_data = 32'hFC00_0000; run = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cyc++;
      #1;
      if (k == 0) op_seen = alu_op;
      if (inst_req) begin
        to = 1'b0;
        break;
      end
    end
    run = 1'b0;
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] r1, r2;
    int          dly;
    bit          drop;
    logic [2:0]  op;
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        zf;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int          cyc, dly, nd, k;
    logic [2:0]  op;
    bit          to, drop, legal;
    logic [31:0] w, rv;
    logic [4:0]  ra;

    fn_tab[0] = 6'h24; fn_tab[1] = 6'h25; fn_tab[2] = 6'h26; fn_tab[3] = 6'h27;
    fn_tab[4] = 6'h20; fn_tab[5] = 6'h22; fn_tab[6] = 6'h2B; fn_tab[7] = 6'h04;

    tbl[0] = '{32'h0022_1820, 32'd5,      32'd3,      0, 1'b0, 3'b100, 4, 5'd3, 32'd8,    1'b0, 32'd4};
    tbl[1] = '{32'h0022_2022, 32'd5,      32'd5,      0, 1'b0, 3'b101, 4, 5'd4, 32'd0,    1'b1, 32'd8};
    tbl[2] = '{32'h0022_2804, 32'd5,      32'd3,      0, 1'b0, 3'b111, 4, 5'd5, 32'd96,   1'b0, 32'd12};
    tbl[3] = '{32'h0022_1820, 32'd7,      32'd9,      3, 1'b1, 3'b100, 7, 5'd3, 32'd16,   1'b0, 32'd16};
    tbl[4] = '{32'h0022_0020, 32'd1,      32'd2,      0, 1'b0, 3'b100, 4, 5'd0, 32'd0,    1'b0, 32'd20};
    tbl[5] = '{32'h0022_3024, 32'hF0F0,   32'h0FF0,   0, 1'b0, 3'b000, 4, 5'd6, 32'h00F0, 1'b0, 32'd24};
    tbl[6] = '{32'h0022_382B, 32'd3,      32'd9,      1, 1'b0, 3'b110, 5, 5'd7, 32'd1,    1'b0, 32'd28};

    rst_n = 1'b0; run = 1'b0; inst_ack = 1'b0; inst_data = 32'd0;
    dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_inst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_pc", inst_addr, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_flags", {28'd0, zf, of, halted, illegal}, 32'd0);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      dbg_write(5'd1, tbl[i].r1);
      dbg_write(5'd2, tbl[i].r2);
      run_inst(tbl[i].word, tbl[i].dly, tbl[i].drop, cyc, op, to);
      model_apply(tbl[i].word);
      chk($sformatf("tbl%0d_timeout", i), {31'd0, to}, 32'd0);
      chk($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d_op", i), {29'd0, op}, {29'd0, tbl[i].op});
      chk($sformatf("tbl%0d_zf", i), {31'd0, zf}, {31'd0, tbl[i].zf});
      chk($sformatf("tbl%0d_pc", i), inst_addr, tbl[i].pc);
      chk($sformatf("tbl%0d_illegal", i), {31'd0, illegal}, 32'd0);
      @(negedge clk);
      dbg_addr = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_rd", i), dbg_rdata, tbl[i].val);
    end
    dbg_write(5'd0, 32'hDEAD_BEEF);
    chk_reg("dbg_r0", 5'd0);

    // Randomized instructions against the reference model.
    for (int it = 0; it < 40; it++) begin
      nd = $urandom_range(0, 2);
      for (int j = 0; j < nd; j++) begin
        ra = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
          0: rv = 32'h7FFF_FFFF;
          1: rv = 32'h8000_0000;
          2: rv = 32'($urandom_range(0, 15));
          default: rv = $urandom;
        endcase
        dbg_write(ra, rv);
      end
      k = $urandom_range(0, 7);
      if ($urandom_range(0, 9) < 8)
        w = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn_tab[k]};
      else
        w = {6'($urandom_range(1, 62)), 26'($urandom)};
      dly = $urandom_range(0, 3);
      drop = 1'($urandom_range(0, 1));
      legal = (w[31:26] == 6'd0);
      run_inst(w, dly, drop, cyc, op, to);
      model_apply(w);
      chk("rnd_timeout", {31'd0, to}, 32'd0);
      chk("rnd_cycles", cyc, 4 + dly);
      if (legal) chk("rnd_op", {29'd0, op}, 32'(k));
      chk("rnd_pc", inst_addr, m_pc);
      chk("rnd_flags", {29'd0, zf, of, illegal}, {29'd0, m_zf, m_of, m_ill});
      chk_reg("rnd_rd", w[15:11]);
    end
    sweep("rnd_sweep");

    // Illegal instruction: sticky flag, no register change, PC advances.
    run_inst(32'hFC00_0000, 0, 1'b0, cyc, op, to);
    model_apply(32'hFC00_0000);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_pc", inst_addr, m_pc);
    chk("ill_cycles", cyc, 4);
    sweep("ill_sweep");

    // Ack without a request must be ignored.
    @(negedge clk);
    inst_ack = 1'b1; inst_data = 32'h0022_1820;
    repeat (2) @(negedge clk);
    inst_ack = 1'b0;
    #1;
    chk("stray_ack_pc", inst_addr, m_pc);
    dbg_write(5'd1, 32'd10);
    dbg_write(5'd2, 32'd20);
    run_inst(32'h0022_1820, 0, 1'b0, cyc, op, to);
    model_apply(32'h0022_1820);
    chk("stray_ack_cycles", cyc, 4);
    chk_reg("stray_ack_r3", 5'd3);

    // PC wrap at the top of the address space.
    @(negedge clk);
    force dut.r_pc = 32'hFFFF_FFFC;
    #1;
    release dut.r_pc;
    m_pc = 32'hFFFF_FFFC;
    run_inst(32'h0022_4025, 0, 1'b0, cyc, op, to);
    model_apply(32'h0022_4025);
    chk("wrap_pc", inst_addr, 32'd0);
    chk_reg("wrap_r8", 5'd8);

    // Reset during EXEC abandons the instruction; ack on the reset edge is ignored.
    dbg_write(5'd1, 32'd5);
    dbg_write(5'd2, 32'd3);
    @(negedge clk);
    run = 1'b1;
    #1;
    inst_ack = 1'b1; inst_data = 32'h0022_1820;
    @(negedge clk);
    inst_ack = 1'b0; run = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; run = 1'b1; inst_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0; inst_ack = 1'b0;
    model_reset();
    #1;
    chk("rst2_inst_req", {31'd0, inst_req}, 32'd0);
    chk("rst2_pc", inst_addr, 32'd0);
    chk("rst2_alu", alu_a | alu_b | {29'd0, alu_op}, 32'd0);
    chk("rst2_flags", {28'd0, zf, of, halted, illegal}, 32'd0);
    chk_reg("rst2", 5'd3);
    chk_reg("rst2", 5'd1);
    dbg_write(5'd1, 32'd4);
    run_inst(32'h0021_1820, 0, 1'b0, cyc, op, to);
    model_apply(32'h0021_1820);
    chk("rst2_cycles", cyc, 4);
    chk("rst2_pc_after", inst_addr, 32'd4);
    chk_reg("rst2_r3", 5'd3);

    // HALT word: terminal, no fetch, debug writes ignored.
    run_inst(32'hFFFF_FFFF, 0, 1'b0, cyc, op, to);
    model_apply(32'hFFFF_FFFF);
    chk("halt_no_refetch", {31'd0, to}, 32'd1);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("halt_req", {31'd0, inst_req}, 32'd0);
    run = 1'b0;
    dbg_write(5'd9, 32'h0000_1234);
    chk_reg("halt_dbg", 5'd9);
    chk_reg("halt_keep", 5'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
